// File: rtl/iq_sample_fifo_if.sv
// Push/pull handshake and status bundle between the LVDS deserialiser, the
// I/Q sample FIFO and the SMI readout controller.
interface iq_sample_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  o_full;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_rd_data, o_rd_valid, o_full, o_empty, o_level,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_rd_data, o_rd_valid, o_full, o_empty, o_level,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/iq_sample_fifo.sv
// Single-clock I/Q sample FIFO on inferable block RAM with registered status,
// one-cycle read latency and sticky overflow/underflow flags.
module iq_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic            i_sys_clk,
  input  logic            i_reset,
  iq_sample_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pull;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // Acceptance uses the registered flags, so a push on empty or a pull on
  // full still goes through while the opposite request is refused.
  always_comb begin
    push       = bus.i_wr_en && !full;
    pull       = bus.i_rd_en && !empty;
    level_next = level;
    case ({push, pull})
      2'b10:   level_next = level + ONE;
      2'b01:   level_next = level - ONE;
      default: level_next = level;
    endcase
  end

  // Storage: no reset so the array maps onto block RAM.
  always_ff @(posedge i_sys_clk) begin
    if (push && !i_reset) begin
      mem[wr_ptr] <= bus.i_wr_data;
    end
  end

  // Stage p1: registered read word, valid strobe, pointers and status.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= pull;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pull) begin
        rd_data_p1 <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      level <= level_next;
      full  <= (level_next == DEPTH);
      empty <= (level_next == '0);
      if (bus.i_wr_en && full) begin
        overflow <= 1'b1;
      end
      if (bus.i_rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.o_rd_data   = rd_data_p1;
  assign bus.o_rd_valid  = vld_p1;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_level     = level;
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo: reset, ordering, full/empty corners,
// sticky error flags, pointer wrap and mid-operation reset.
module tb_iq_sample_fifo;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;

  iq_sample_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  iq_sample_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    int rd_idx;
    total_cnt     = 0;
    pass_cnt      = 0;
    rst           = 1'b1;
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    chk("rst_empty", bus.o_empty, 1);
    chk("rst_full", bus.o_full, 0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_valid", bus.o_rd_valid, 0);
    chk("rst_data", bus.o_rd_data, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    chk("rst_unf", bus.o_underflow, 0);

    // Push 1..4, then pull 4
    for (int k = 1; k <= 4; k++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = k;
      tick();
      chk($sformatf("push_level_%0d", k), bus.o_level, k);
    end
    bus.i_wr_en = 1'b0;
    chk("four_not_empty", bus.o_empty, 0);
    for (int k = 1; k <= 4; k++) begin
      bus.i_rd_en = 1'b1;
      tick();
      chk($sformatf("pull_level_%0d", k), bus.o_level, 4 - k);
      chk($sformatf("pull_valid_%0d", k), bus.o_rd_valid, 1);
      chk($sformatf("pull_data_%0d", k), bus.o_rd_data, k);
    end
    bus.i_rd_en = 1'b0;
    tick();
    chk("idle_valid_low", bus.o_rd_valid, 0);
    chk("idle_data_hold", bus.o_rd_data, 4);
    chk("four_drained_empty", bus.o_empty, 1);
    chk("four_no_unf", bus.o_underflow, 0);

    // Fill to 1024, overflow attempt, drain
    for (int i = 0; i < 1024; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = i;
      tick();
    end
    chk("fill_full", bus.o_full, 1);
    chk("fill_level", bus.o_level, 1024);
    chk("fill_no_ovf", bus.o_overflow, 0);
    bus.i_wr_data = 32'hDEADBEEF;
    tick();
    bus.i_wr_en = 1'b0;
    chk("ovf_set", bus.o_overflow, 1);
    chk("ovf_level", bus.o_level, 1024);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      bus.i_rd_en = 1'b1;
      tick();
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 32'(i)) bad++;
    end
    bus.i_rd_en = 1'b0;
    chk("drain_seq_errors", bad, 0);
    chk("drain_empty", bus.o_empty, 1);
    chk("ovf_sticky", bus.o_overflow, 1);

    // Full with simultaneous push and pull
    do_reset();
    chk("rst_clears_ovf", bus.o_overflow, 0);
    for (int i = 0; i < 1024; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = i;
      tick();
    end
    bus.i_rd_en   = 1'b1;
    bus.i_wr_data = 32'h12345678;
    tick();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    chk("full_rw_valid", bus.o_rd_valid, 1);
    chk("full_rw_data", bus.o_rd_data, 0);
    chk("full_rw_ovf", bus.o_overflow, 1);
    chk("full_rw_level", bus.o_level, 1023);
    chk("full_rw_not_full", bus.o_full, 0);

    // Five words held, simultaneous push and pull
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = 32'h50 + i;
      tick();
    end
    bus.i_rd_en   = 1'b1;
    bus.i_wr_data = 32'h77;
    tick();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    chk("mid_rw_level", bus.o_level, 5);
    chk("mid_rw_data", bus.o_rd_data, 32'h50);
    chk("mid_rw_ovf", bus.o_overflow, 0);
    chk("mid_rw_unf", bus.o_underflow, 0);

    // Empty with simultaneous pull and push
    do_reset();
    bus.i_wr_en   = 1'b1;
    bus.i_rd_en   = 1'b1;
    bus.i_wr_data = 32'hA5A5A5A5;
    tick();
    bus.i_wr_en = 1'b0;
    chk("empty_rw_unf", bus.o_underflow, 1);
    chk("empty_rw_valid", bus.o_rd_valid, 0);
    chk("empty_rw_level", bus.o_level, 1);
    tick();
    bus.i_rd_en = 1'b0;
    chk("empty_rw_read_valid", bus.o_rd_valid, 1);
    chk("empty_rw_read_data", bus.o_rd_data, 32'hA5A5A5A5);
    chk("empty_rw_drained", bus.o_empty, 1);

    // Wrap: 512 preloaded, 3000 interleaved, then drain
    do_reset();
    for (int i = 0; i < 512; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = 32'h1000_0000 + i;
      tick();
    end
    bad    = 0;
    rd_idx = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_rd_en   = 1'b1;
      bus.i_wr_data = 32'h1000_0000 + 512 + i;
      tick();
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 32'h1000_0000 + 32'(rd_idx)) bad++;
      rd_idx++;
    end
    bus.i_wr_en = 1'b0;
    chk("wrap_level", bus.o_level, 512);
    for (int i = 0; i < 512; i++) begin
      tick();
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== 32'h1000_0000 + 32'(rd_idx)) bad++;
      rd_idx++;
    end
    bus.i_rd_en = 1'b0;
    chk("wrap_seq_errors", bad, 0);
    chk("wrap_empty", bus.o_empty, 1);
    chk("wrap_flags", {bus.o_overflow, bus.o_underflow}, 0);

    // Reset with 10 words stored and underflow set
    bus.i_rd_en = 1'b1;
    tick();
    bus.i_rd_en = 1'b0;
    chk("pre_rst_unf", bus.o_underflow, 1);
    for (int i = 0; i < 10; i++) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_data = 32'h900 + i;
      tick();
    end
    chk("pre_rst_level", bus.o_level, 10);
    do_reset();
    chk("mid_rst_empty", bus.o_empty, 1);
    chk("mid_rst_level", bus.o_level, 0);
    chk("mid_rst_flags", {bus.o_overflow, bus.o_underflow}, 0);
    chk("mid_rst_data", bus.o_rd_data, 0);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = 32'hCAFEF00D;
    tick();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b1;
    tick();
    bus.i_rd_en = 1'b0;
    chk("post_rst_valid", bus.o_rd_valid, 1);
    chk("post_rst_data", bus.o_rd_data, 32'hCAFEF00D);
    chk("post_rst_empty", bus.o_empty, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
